// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register map,
// CONTROL field positions, compare reset value and the byte-lane merge helper.
// No logic of its own; imported by mmio_timer and mmio_timer_comparator.
package mmio_timer_pkg;

  // Byte offsets from BASE_ADDRESS
  localparam logic [31:0] OFF_MTIME        = 32'h00;
  localparam logic [31:0] OFF_MTIMEH       = 32'h04;
  localparam logic [31:0] OFF_CONTROL      = 32'h08;
  localparam logic [31:0] OFF_IE           = 32'h0C;
  localparam logic [31:0] OFF_PENDING      = 32'h10;
  localparam logic [31:0] OFF_COMPARE_BASE = 32'h20;
  localparam logic [31:0] COMPARE_STRIDE   = 32'h08;

  // CONTROL layout
  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;
  localparam logic [31:0] CONTROL_RESET     = 32'h0000_0001;

  // Compare registers reset to the largest value so nothing fires after reset
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes flagged in sections; other bytes keep old_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sections);
    logic [31:0] result;
    result = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sections[b]) result[8*b +: 8] = wdata[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mmio_timer_comparator.sv
// One timer compare channel: 64-bit MTIMECMP register with byte-lane writes,
// unsigned mtime >= mtimecmp compare, and registered level interrupt gated by IE.
// Interrupt latency 1 cycle from compare condition; no backpressure (writes always accepted).
// Ports: clk_i/rst_i clock and async active-high reset; mtime_i current counter;
//        wr_lo_i/wr_hi_i half select strobes with wdata_i/sections_i; ie_i enable;
//        cmp_o register value for readback; pending_o raw compare; irq_o registered interrupt.
module mmio_timer_comparator
  import mmio_timer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] mtime_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sections_i,
  input  logic        ie_i,
  output logic [63:0] cmp_o,
  output logic        pending_o,
  output logic        irq_o
);

  logic [63:0] cmp_q, cmp_d;
  logic        irq_q;

  always_comb begin
    cmp_d = cmp_q;
    if (wr_lo_i) cmp_d[31:0]  = merge_bytes(cmp_q[31:0],  wdata_i, sections_i);
    if (wr_hi_i) cmp_d[63:32] = merge_bytes(cmp_q[63:32], wdata_i, sections_i);
  end

  // Compare against the pre-edge register value, so a write landing on the
  // same edge as an mtime crossing is judged on the old compare value.
  assign pending_o = (mtime_i >= cmp_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_q <= MTIMECMP_RESET;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      irq_q <= pending_o & ie_i;
    end
  end

  assign cmp_o = cmp_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, NUM_COMPARE compare channels, tear-free reads.
// Read latency 1 cycle (read_value/read_hit registered); interrupts 1 cycle after compare condition.
// No backpressure: every bus access completes in the cycle it is presented.
// Ports: clk24 bus clock; reset async active-high; memory_address/memory_write_value/
//        memory_write_sections bus request (sections==0 means read); read_value/read_hit
//        registered response; timer_interrupt per-channel level interrupt; mip_mtip OR of them.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000,
  parameter int unsigned NUM_COMPARE    = 1,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                   clk24,
  input  logic                   reset,
  input  logic [31:0]            memory_address,
  input  logic [31:0]            memory_write_value,
  input  logic [3:0]             memory_write_sections,
  output logic [31:0]            read_value,
  output logic                   read_hit,
  output logic [NUM_COMPARE-1:0] timer_interrupt,
  output logic                   mip_mtip
);

  localparam logic [31:0] WINDOW_BYTES = OFF_COMPARE_BASE + COMPARE_STRIDE * 32'(NUM_COMPARE);
  localparam logic [31:0] CTRL_MASK =
    (((32'd1 << PRESCALE_WIDTH) - 32'd1) << CTRL_PRESCALE_LSB) | (32'd1 << CTRL_EN_BIT);
  localparam logic [31:0] IE_MASK = 32'((64'd1 << NUM_COMPARE) - 64'd1);

  // ---------------- address decode ----------------
  logic [31:0] offset;
  logic [31:0] word_off;
  logic        in_window;
  logic        wr_any;
  logic        sel_mtime, sel_mtimeh, sel_control, sel_ie, sel_pending;
  logic [NUM_COMPARE-1:0] sel_cmp_lo, sel_cmp_hi;

  // Addresses below the base wrap to large offsets and fall outside the window.
  assign offset    = memory_address - BASE_ADDRESS;
  assign in_window = (offset < WINDOW_BYTES);
  assign word_off  = {offset[31:2], 2'b00};
  assign wr_any    = in_window && (memory_write_sections != 4'b0000);

  assign sel_mtime   = in_window && (word_off == OFF_MTIME);
  assign sel_mtimeh  = in_window && (word_off == OFF_MTIMEH);
  assign sel_control = in_window && (word_off == OFF_CONTROL);
  assign sel_ie      = in_window && (word_off == OFF_IE);
  assign sel_pending = in_window && (word_off == OFF_PENDING);

  always_comb begin
    sel_cmp_lo = '0;
    sel_cmp_hi = '0;
    for (int i = 0; i < NUM_COMPARE; i++) begin
      sel_cmp_lo[i] = in_window && (word_off == OFF_COMPARE_BASE + COMPARE_STRIDE * 32'(i));
      sel_cmp_hi[i] = in_window && (word_off == OFF_COMPARE_BASE + COMPARE_STRIDE * 32'(i) + 32'd4);
    end
  end

  // ---------------- state ----------------
  logic [63:0]               mtime_q, mtime_d;
  logic [31:0]               snapshot_q, snapshot_d;
  logic [31:0]               control_q, control_d;
  logic [31:0]               ie_q, ie_d;
  logic [PRESCALE_WIDTH-1:0] prescale_count_q, prescale_count_d;
  logic [31:0]               read_value_q, read_value_d;
  logic                      read_hit_q;

  logic                      count_en;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      tick;

  assign count_en = control_q[CTRL_EN_BIT];
  assign prescale = control_q[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
  assign tick     = count_en && (prescale_count_q == prescale);

  // Prescaler keeps running even on cycles where mtime is being written.
  always_comb begin
    prescale_count_d = prescale_count_q;
    if (wr_any && sel_control) prescale_count_d = '0;
    else if (count_en)         prescale_count_d = tick ? '0 : prescale_count_q + PRESCALE_WIDTH'(1);
  end

  // A write to either half takes priority over the increment for that cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_any && sel_mtime)
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], memory_write_value, memory_write_sections);
    else if (wr_any && sel_mtimeh)
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], memory_write_value, memory_write_sections);
    else if (tick)
      mtime_d = mtime_q + 64'd1;
  end

  // The high half is latched on the same edge the low half is returned, so an
  // MTIME/MTIMEH read pair always describes one instant of the counter.
  always_comb begin
    snapshot_d = snapshot_q;
    if (wr_any && sel_mtimeh)
      snapshot_d = merge_bytes(mtime_q[63:32], memory_write_value, memory_write_sections);
    else if (sel_mtime)
      snapshot_d = mtime_q[63:32];
  end

  always_comb begin
    control_d = control_q;
    ie_d      = ie_q;
    if (wr_any && sel_control)
      control_d = merge_bytes(control_q, memory_write_value, memory_write_sections) & CTRL_MASK;
    if (wr_any && sel_ie)
      ie_d = merge_bytes(ie_q, memory_write_value, memory_write_sections) & IE_MASK;
  end

  // ---------------- compare channels ----------------
  logic [63:0]            cmp_val [NUM_COMPARE];
  logic [NUM_COMPARE-1:0] pending;
  logic [NUM_COMPARE-1:0] irq;

  for (genvar g = 0; g < NUM_COMPARE; g++) begin : g_cmp
    mmio_timer_comparator u_cmp (
      .clk_i      (clk24),
      .rst_i      (reset),
      .mtime_i    (mtime_q),
      .wr_lo_i    (wr_any && sel_cmp_lo[g]),
      .wr_hi_i    (wr_any && sel_cmp_hi[g]),
      .wdata_i    (memory_write_value),
      .sections_i (memory_write_sections),
      .ie_i       (ie_q[g]),
      .cmp_o      (cmp_val[g]),
      .pending_o  (pending[g]),
      .irq_o      (irq[g])
    );
  end

  // ---------------- read mux ----------------
  always_comb begin
    read_value_d = 32'd0;
    if (sel_mtime)        read_value_d = mtime_q[31:0];
    else if (sel_mtimeh)  read_value_d = snapshot_q;
    else if (sel_control) read_value_d = control_q;
    else if (sel_ie)      read_value_d = ie_q;
    else if (sel_pending) read_value_d = 32'(pending);
    for (int i = 0; i < NUM_COMPARE; i++) begin
      if (sel_cmp_lo[i]) read_value_d = cmp_val[i][31:0];
      if (sel_cmp_hi[i]) read_value_d = cmp_val[i][63:32];
    end
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      mtime_q          <= 64'd0;
      snapshot_q       <= 32'd0;
      control_q        <= CONTROL_RESET;
      ie_q             <= IE_MASK;
      prescale_count_q <= '0;
      read_value_q     <= 32'd0;
      read_hit_q       <= 1'b0;
    end else begin
      mtime_q          <= mtime_d;
      snapshot_q       <= snapshot_d;
      control_q        <= control_d;
      ie_q             <= ie_d;
      prescale_count_q <= prescale_count_d;
      read_value_q     <= read_value_d;
      read_hit_q       <= in_window;
    end
  end

  assign read_value      = read_value_q;
  assign read_hit        = read_hit_q;
  assign timer_interrupt = irq;
  assign mip_mtip        = |irq;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer with two compare channels.
// Inputs change and outputs are sampled on the falling edge of clk24.
// Each bus access occupies exactly one rising edge; expected values are hand-computed.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] IDLE = 32'h0000_0000;

  logic        clk24 = 1'b0;
  logic        reset;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic [3:0]  memory_write_sections;
  logic [31:0] read_value;
  logic        read_hit;
  logic [1:0]  timer_interrupt;
  logic        mip_mtip;

  int tests    = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        hit;

  mmio_timer #(
    .BASE_ADDRESS   (BASE),
    .NUM_COMPARE    (2),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk24                 (clk24),
    .reset                 (reset),
    .memory_address        (memory_address),
    .memory_write_value    (memory_write_value),
    .memory_write_sections (memory_write_sections),
    .read_value            (read_value),
    .read_hit              (read_hit),
    .timer_interrupt       (timer_interrupt),
    .mip_mtip              (mip_mtip)
  );

  always #5 clk24 = ~clk24;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for one rising edge, capture the response at the next falling edge.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdat, input logic [3:0] sec);
    memory_address        = addr;
    memory_write_value    = wdat;
    memory_write_sections = sec;
    @(negedge clk24);
    rd  = read_value;
    hit = read_hit;
    memory_address        = IDLE;
    memory_write_value    = 32'd0;
    memory_write_sections = 4'd0;
  endtask

  task automatic rd_reg(input logic [31:0] off);
    access(BASE + off, 32'd0, 4'b0000);
  endtask

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] val, input logic [3:0] sec);
    access(BASE + off, val, sec);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk24);
  endtask

  initial begin
    reset                 = 1'b1;
    memory_address        = IDLE;
    memory_write_value    = 32'd0;
    memory_write_sections = 4'd0;
    wait_cycles(2);
    check("reset read_value", 64'(read_value), 64'd0);
    check("reset read_hit", 64'(read_hit), 64'd0);
    check("reset timer_interrupt", 64'(timer_interrupt), 64'd0);
    check("reset mip_mtip", 64'(mip_mtip), 64'd0);
    reset = 1'b0;

    // Prescale 0: one increment per edge; 10 edges then sample
    wait_cycles(10);
    rd_reg(32'h00);
    check("mtime after 10", 64'(rd), 64'd10);
    check("mtime read_hit", 64'(hit), 64'd1);
    rd_reg(32'h04);
    check("mtimeh after 10", 64'(rd), 64'd0);
    check("mip idle", 64'(mip_mtip), 64'd0);
    check("tint idle", 64'(timer_interrupt), 64'd0);
    rd_reg(32'h10);
    check("pending idle", 64'(rd), 64'd0);
    rd_reg(32'h08);
    check("control reset", 64'(rd), 64'h1);
    rd_reg(32'h0C);
    check("ie reset", 64'(rd), 64'h3);
    rd_reg(32'h14);
    check("hole value", 64'(rd), 64'd0);
    check("hole hit", 64'(hit), 64'd1);
    access(BASE + 32'h30, 32'd0, 4'b0000);
    check("past window value", 64'(rd), 64'd0);
    check("past window hit", 64'(hit), 64'd0);
    access(32'h7FFF_FFFC, 32'd0, 4'b0000);
    check("below base hit", 64'(hit), 64'd0);

    // Prescale 3: the CONTROL write edge still ticks (old prescale 0) -> 19
    wr_reg(32'h08, 32'h0000_0301, 4'b0011);
    rd_reg(32'h00);
    check("mtime at prescale start", 64'(rd), 64'd19);
    wait_cycles(39);
    rd_reg(32'h00);
    check("mtime after 40 cycles /4", 64'(rd), 64'd29);
    wr_reg(32'h08, 32'h0000_0300, 4'b0001);
    wait_cycles(20);
    rd_reg(32'h00);
    check("mtime frozen", 64'(rd), 64'd29);
    rd_reg(32'h08);
    check("control disabled", 64'(rd), 64'h300);

    // Tear-free pair across the 32-bit carry
    wr_reg(32'h00, 32'hFFFF_FFFE, 4'b1111);
    wr_reg(32'h04, 32'h0000_0000, 4'b1111);
    wr_reg(32'h08, 32'h0000_0001, 4'b0011);
    wait_cycles(1);
    rd_reg(32'h00);
    check("pair1 low", 64'(rd), 64'hFFFF_FFFF);
    rd_reg(32'h04);
    check("pair1 high", 64'(rd), 64'd0);
    rd_reg(32'h00);
    check("pair2 low", 64'(rd), 64'd1);
    rd_reg(32'h04);
    check("pair2 high", 64'(rd), 64'd1);
    wr_reg(32'h04, 32'h0000_0005, 4'b0001);
    rd_reg(32'h04);
    check("mtimeh write loads snapshot", 64'(rd), 64'd5);

    // Two compare channels at 100 and 200
    wr_reg(32'h08, 32'h0000_0000, 4'b0001);
    wr_reg(32'h00, 32'd97, 4'b1111);
    wr_reg(32'h04, 32'd0, 4'b1111);
    wr_reg(32'h20, 32'd100, 4'b1111);
    wr_reg(32'h24, 32'd0, 4'b1111);
    wr_reg(32'h28, 32'd200, 4'b1111);
    wr_reg(32'h2C, 32'd0, 4'b1111);
    rd_reg(32'h10);
    check("pending before", 64'(rd), 64'd0);
    rd_reg(32'h20);
    check("cmp0 low readback", 64'(rd), 64'd100);
    rd_reg(32'h2C);
    check("cmp1 high readback", 64'(rd), 64'd0);
    wr_reg(32'h08, 32'h0000_0001, 4'b0001);
    wait_cycles(3);
    check("tint as mtime hits 100", 64'(timer_interrupt), 64'b00);
    wait_cycles(1);
    check("tint one cycle after 100", 64'(timer_interrupt), 64'b01);
    check("mip after 100", 64'(mip_mtip), 64'd1);
    wait_cycles(99);
    check("tint as mtime hits 200", 64'(timer_interrupt), 64'b01);
    wait_cycles(1);
    check("tint one cycle after 200", 64'(timer_interrupt), 64'b11);
    rd_reg(32'h10);
    check("pending both", 64'(rd), 64'b11);

    // IE[0] cleared: interrupt drops one cycle later, pending unaffected
    wr_reg(32'h0C, 32'h0000_0002, 4'b0001);
    check("tint on IE write edge", 64'(timer_interrupt), 64'b11);
    wait_cycles(1);
    check("tint after IE clear", 64'(timer_interrupt), 64'b10);
    rd_reg(32'h10);
    check("pending with IE0 off", 64'(rd), 64'b11);
    rd_reg(32'h0C);
    check("ie readback", 64'(rd), 64'h2);
    wr_reg(32'h20, 32'hAABB_CCDD, 4'b0010);
    rd_reg(32'h20);
    check("cmp0 byte1 write", 64'(rd), 64'h0000_CC64);
    rd_reg(32'h24);
    check("cmp0 high untouched", 64'(rd), 64'd0);
    rd_reg(32'h10);
    check("pending after raise", 64'(rd), 64'b10);

    // Reset in the middle of a prescale-5 period
    wr_reg(32'h08, 32'h0000_0501, 4'b0011);
    wait_cycles(3);
    rd_reg(32'h08);
    check("control prescale 5", 64'(rd), 64'h501);
    reset = 1'b1;
    #1;
    check("mid reset read_value", 64'(read_value), 64'd0);
    check("mid reset read_hit", 64'(read_hit), 64'd0);
    check("mid reset tint", 64'(timer_interrupt), 64'd0);
    check("mid reset mip", 64'(mip_mtip), 64'd0);
    @(negedge clk24);
    reset = 1'b0;
    rd_reg(32'h08);
    check("control after reset", 64'(rd), 64'h1);
    rd_reg(32'h00);
    check("mtime restart 1", 64'(rd), 64'd1);
    rd_reg(32'h00);
    check("mtime restart 2", 64'(rd), 64'd2);
    rd_reg(32'h04);
    check("mtimeh after reset", 64'(rd), 64'd0);
    rd_reg(32'h0C);
    check("ie after reset", 64'(rd), 64'h3);
    rd_reg(32'h20);
    check("cmp0 low after reset", 64'(rd), 64'hFFFF_FFFF);
    rd_reg(32'h2C);
    check("cmp1 high after reset", 64'(rd), 64'hFFFF_FFFF);
    check("tint after reset", 64'(timer_interrupt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
